// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: default widths and the writeback result
// source encoding used by the result select and the register file.
package riscv_pkg;

  localparam int unsigned XLEN_DEF          = 32;
  localparam int unsigned REG_ADDR_W_DEF    = 5;
  localparam int unsigned RESULT_SRC_W      = 2;
  localparam int unsigned WB_COUNT_W        = 32;

  // Writeback result source; RES_RSVD selects zero.
  typedef enum logic [RESULT_SRC_W-1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } result_src_e;

endpackage : riscv_pkg

// File: rtl/result_mux.sv
// Writeback result select (pure combinational).
// Ports:
//   result_src_i  - result source select (result_src_e encoding)
//   alu_result_i  - ALU result candidate
//   read_data_i   - load data candidate
//   pc_plus4_i    - PC+4 (link) candidate
//   result_o      - selected value, zero for the reserved encoding
module result_mux
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN_DEF
) (
  input  logic [RESULT_SRC_W-1:0] result_src_i,
  input  logic [DATA_WIDTH-1:0]   alu_result_i,
  input  logic [DATA_WIDTH-1:0]   read_data_i,
  input  logic [DATA_WIDTH-1:0]   pc_plus4_i,
  output logic [DATA_WIDTH-1:0]   result_o
);

  always_comb begin
    result_o = '0;
    unique case (result_src_e'(result_src_i))
      RES_ALU:  result_o = alu_result_i;
      RES_MEM:  result_o = read_data_i;
      RES_PC4:  result_o = pc_plus4_i;
      RES_RSVD: result_o = '0;
      default:  result_o = '0;
    endcase
  end

endmodule : result_mux

// File: rtl/writeback_regfile.sv
// Writeback stage plus integer register file: selects the writeback result,
// commits it into a flop array, and serves two decode read ports with
// write-first bypass and a bypass-free debug read port. Counts commits.
// Ports:
//   clk, rst_n            - clock, async active-low reset (clears array/count)
//   RegWriteW, RdW        - writeback enable and destination (x0 ignored)
//   ResultSrcW            - result select: ALU / load / PC+4 / zero
//   ALUResultW, ReadDataW, PCPlus4W - result candidates
//   ResultW               - selected writeback value (combinational)
//   Rs1D, Rs2D / RD1D, RD2D - decode read ports (combinational, bypassed)
//   DbgAddr / DbgData     - debug read port (array contents only)
//   WbCount               - committed write counter, wraps
module writeback_regfile
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH             = XLEN_DEF,
  parameter int unsigned REG_FILE_ADDRESS_WIDTH = REG_ADDR_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              RegWriteW,
  input  logic [RESULT_SRC_W-1:0]           ResultSrcW,
  input  logic [DATA_WIDTH-1:0]             ALUResultW,
  input  logic [DATA_WIDTH-1:0]             ReadDataW,
  input  logic [DATA_WIDTH-1:0]             PCPlus4W,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdW,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs1D,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs2D,
  output logic [DATA_WIDTH-1:0]             RD1D,
  output logic [DATA_WIDTH-1:0]             RD2D,
  output logic [DATA_WIDTH-1:0]             ResultW,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] DbgAddr,
  output logic [DATA_WIDTH-1:0]             DbgData,
  output logic [WB_COUNT_W-1:0]             WbCount
);

  localparam int unsigned NUM_REGS = 1 << REG_FILE_ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [WB_COUNT_W-1:0] wb_count_q;
  logic [WB_COUNT_W-1:0] wb_count_d;
  logic                  commit_c;

  // Result selection lives in its own combinational block.
  result_mux #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_result_mux (
    .result_src_i (ResultSrcW),
    .alu_result_i (ALUResultW),
    .read_data_i  (ReadDataW),
    .pc_plus4_i   (PCPlus4W),
    .result_o     (ResultW)
  );

  // Writes to x0 are dropped entirely, including from the counter.
  assign commit_c   = RegWriteW && (RdW != '0);
  assign wb_count_d = commit_c ? wb_count_q + WB_COUNT_W'(1) : wb_count_q;

  // Register array and commit counter; entry 0 is reset and never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else begin
      if (commit_c) begin
        regs_q[RdW] <= ResultW;
      end
      wb_count_q <= wb_count_d;
    end
  end

  // Decode reads: write-first bypass, also active while in reset so an
  // in-flight result still reaches decode.
  always_comb begin
    RD1D = '0;
    RD2D = '0;
    if (Rs1D != '0) begin
      RD1D = (commit_c && (RdW == Rs1D)) ? ResultW : regs_q[Rs1D];
    end
    if (Rs2D != '0) begin
      RD2D = (commit_c && (RdW == Rs2D)) ? ResultW : regs_q[Rs2D];
    end
  end

  // Debug read sees stored contents only.
  assign DbgData = (DbgAddr == '0) ? '0 : regs_q[DbgAddr];
  assign WbCount = wb_count_q;

endmodule : writeback_regfile
